cmp_seq_ctrl: RTL and testbench

CMP_SEQ_CTRL -- requirements
Module: cmp_seq_ctrl

---
 rtl/cmp_seq_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_cmp_seq_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cmp_seq_ctrl
//   Sequential wide-operand comparator. Compares two NWORDS x 32-bit operands
//   one 32-bit word per cycle, most significant word first, so the whole
//   compare shares a single 32-bit magnitude comparator. The compare stops at
//   the first differing word. Signed mode flips the sign bit of the top word
//   only, which turns the unsigned word compare into a two's-complement one.
//
// Ports
//   i_clk          rising-edge clock for all state
//   i_rst          synchronous, active-high reset
//   i_req_valid    request offered
//   o_req_ready    block can accept a request (IDLE only)
//   i_req_signed   1 = two's-complement compare, 0 = unsigned
//   i_operand_a    operand A, word k at bits [32k+31:32k]
//   i_operand_b    operand B, same layout as A
//   o_rsp_valid    result available (RESP only)
//   i_rsp_ready    consumer accepts the result
//   o_eq/o_lt/o_gt one-hot compare result, valid with o_rsp_valid
//   o_cycles       number of word compares performed (1..NWORDS)
// -----------------------------------------------------------------------------
module cmp_seq_ctrl #(
  parameter int NWORDS = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_signed,
  input  logic [NWORDS*32-1:0]   i_operand_a,
  input  logic [NWORDS*32-1:0]   i_operand_b,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic                   o_eq,
  output logic                   o_lt,
  output logic                   o_gt,
  output logic [4:0]             o_cycles
);

  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [31:0]     a_words [NWORDS];
  logic [31:0]     b_words [NWORDS];
  logic            signed_mode;
  logic [IW-1:0]   idx;
  logic [4:0]      count;
  logic            res_eq;
  logic            res_lt;
  logic            res_gt;
  // Set by reset and cleared on the first edge without reset, so the block
  // stays not-ready for one full cycle after reset is released.
  logic            rst_hold;

  logic            req_ready;
  logic            rsp_valid;
  logic            accept;

  logic [31:0]     word_a;
  logic [31:0]     word_b;
  logic            word_lt;
  logic            word_gt;

  // ---------------------------------------------------------------------------
  // Single shared 32-bit word comparator
  // ---------------------------------------------------------------------------
  always_comb begin
    word_a = a_words[idx];
    word_b = b_words[idx];
    // Inverting the sign bit maps two's-complement order onto unsigned order;
    // only the most significant word carries the sign.
    if (signed_mode && (idx == TOP_IDX)) begin
      word_a[31] = ~word_a[31];
      word_b[31] = ~word_b[31];
    end
    word_lt = (word_a < word_b);
    word_gt = (word_a > word_b);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = ~rst_hold;
        if (i_req_valid && !rst_hold) begin
          state_nxt = CMP;
        end
      end
      CMP: begin
        if (word_lt || word_gt || (idx == '0)) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign accept = (state == IDLE) && req_ready && i_req_valid;

  // Reset forces every output low even before the first reset edge lands.
  assign o_req_ready = req_ready & ~i_rst;
  assign o_rsp_valid = rsp_valid & ~i_rst;
  assign o_eq        = o_rsp_valid & res_eq;
  assign o_lt        = o_rsp_valid & res_lt;
  assign o_gt        = o_rsp_valid & res_gt;
  assign o_cycles    = o_rsp_valid ? count : 5'd0;

  // ---------------------------------------------------------------------------
  // Operand capture
  // ---------------------------------------------------------------------------
  // NOTE: the operand word storage has no reset; it is always written on
  // accept before it is read, and leaving it out of reset keeps it plain
  // flops without a reset network.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int k = 0; k < NWORDS; k++) begin
        a_words[k] <= i_operand_a[k*32 +: 32];
        b_words[k] <= i_operand_b[k*32 +: 32];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing state: word index, compare count, latched result
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rst_hold    <= 1'b1;
      signed_mode <= 1'b0;
      idx         <= '0;
      count       <= '0;
      res_eq      <= 1'b0;
      res_lt      <= 1'b0;
      res_gt      <= 1'b0;
    end else begin
      rst_hold <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            signed_mode <= i_req_signed;
            idx         <= TOP_IDX;
            count       <= '0;
            res_eq      <= 1'b0;
            res_lt      <= 1'b0;
            res_gt      <= 1'b0;
          end
        end
        CMP: begin
          count <= count + 5'd1;
          if (word_lt || word_gt) begin
            // First differing word decides the whole compare.
            res_lt <= word_lt;
            res_gt <= word_gt;
          end else if (idx == '0) begin
            res_eq <= 1'b1;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cmp_seq_ctrl
//   Directed self-checking bench for cmp_seq_ctrl with NWORDS=4. Expected
//   results come from a full-width reference compare, are pushed to a queue
//   when a request is driven and popped when the response appears.
// -----------------------------------------------------------------------------
module tb_cmp_seq_ctrl;

  localparam int NW = 4;
  localparam int W  = NW * 32;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_req_valid;
  logic          o_req_ready;
  logic          i_req_signed;
  logic [W-1:0]  i_operand_a;
  logic [W-1:0]  i_operand_b;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic          o_eq;
  logic          o_lt;
  logic          o_gt;
  logic [4:0]    o_cycles;

  typedef struct {
    logic       eq;
    logic       lt;
    logic       gt;
    logic [4:0] cycles;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  cmp_seq_ctrl #(.NWORDS(NW)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_signed (i_req_signed),
    .i_operand_a  (i_operand_a),
    .i_operand_b  (i_operand_b),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_eq         (o_eq),
    .o_lt         (o_lt),
    .o_gt         (o_gt),
    .o_cycles     (o_cycles)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic rv, input logic eq, input logic lt,
                            input logic gt, input logic [4:0] cyc, input logic rdy);
    check({tag, "_rsp_valid"}, o_rsp_valid, rv);
    check({tag, "_eq"},        o_eq,        eq);
    check({tag, "_lt"},        o_lt,        lt);
    check({tag, "_gt"},        o_gt,        gt);
    check({tag, "_cycles"},    o_cycles,    cyc);
    check({tag, "_req_ready"}, o_req_ready, rdy);
  endtask

  function automatic logic [W-1:0] mk(input logic [31:0] w3, input logic [31:0] w2,
                                      input logic [31:0] w1, input logic [31:0] w0);
    return {w3, w2, w1, w0};
  endfunction

  // Reference: full-width compare, cycles = words scanned down to the first
  // difference (or all of them when equal).
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    exp_t e;
    logic found;
    e.eq = (a == b);
    e.lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
    e.gt = !e.eq && !e.lt;
    e.cycles = 5'd0;
    found = 1'b0;
    for (int k = NW - 1; k >= 0; k--) begin
      if (!found) begin
        e.cycles = e.cycles + 5'd1;
        if (a[k*32 +: 32] != b[k*32 +: 32]) found = 1'b1;
      end
    end
    return e;
  endfunction

  // One full transaction. With stress set, the response is held for `hold`
  // cycles while a fresh request is offered, and the consume edge still has
  // i_req_valid high.
  task automatic run_req(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sgn, input int hold, input logic stress);
    int   t;
    int   lat;
    exp_t e;
    t = 0;
    while (!o_req_ready && t < 50) begin
      @(negedge i_clk);
      t++;
    end
    check({tag, "_ready_before"}, o_req_ready, 1'b1);
    i_operand_a  = a;
    i_operand_b  = b;
    i_req_signed = sgn;
    i_req_valid  = 1'b1;
    sb.push_back(model(a, b, sgn));
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid  = 1'b0;
    check({tag, "_busy_ready"}, o_req_ready, 1'b0);
    lat = 0;
    while (!o_rsp_valid && lat < 40) begin
      @(posedge i_clk);
      @(negedge i_clk);
      lat++;
    end
    check({tag, "_sb_nonempty"}, (sb.size() != 0), 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_latency"}, lat, e.cycles);
      check_outs({tag, "_rsp"}, 1'b1, e.eq, e.lt, e.gt, e.cycles, 1'b0);
      for (int i = 0; i < hold; i++) begin
        if (stress) begin
          i_req_valid  = 1'b1;
          i_operand_a  = {$urandom, $urandom, $urandom, $urandom};
          i_operand_b  = {$urandom, $urandom, $urandom, $urandom};
          i_req_signed = ~i_req_signed;
        end
        @(posedge i_clk);
        @(negedge i_clk);
        check_outs({tag, "_hold"}, 1'b1, e.eq, e.lt, e.gt, e.cycles, 1'b0);
      end
    end
    i_rsp_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    // No accept may happen on the consume edge, so the block is back in IDLE.
    check_outs({tag, "_done"}, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    i_req_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;

    i_rst        = 1'b1;
    i_req_valid  = 1'b0;
    i_req_signed = 1'b0;
    i_operand_a  = '0;
    i_operand_b  = '0;
    i_rsp_ready  = 1'b0;

    // Reset behaviour
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check_outs("in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    i_rst = 1'b0;
    #1;
    check_outs("after_reset_c1", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge i_clk);
    check_outs("after_reset_c2", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);

    // Equal 4-word unsigned
    a = mk(32'h0123_4567, 32'h89AB_CDEF, 32'h0000_0000, 32'hFFFF_FFFF);
    run_req("eq_full", a, a, 1'b0, 0, 1'b0);

    // Early termination on the top word
    run_req("lt_top", mk(32'h1, $urandom, $urandom, $urandom),
                      mk(32'h2, $urandom, $urandom, $urandom), 1'b0, 0, 1'b0);

    // Difference only in word 0
    run_req("gt_w0", mk(32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 32'h5),
                     mk(32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 32'h3), 1'b0, 0, 1'b0);

    // Signed vs unsigned interpretation of the top word
    a = mk(32'hFFFF_FFFF, 32'h11, 32'h22, 32'h33);
    b = mk(32'h0000_0001, 32'h11, 32'h22, 32'h33);
    run_req("top_signed",   a, b, 1'b1, 0, 1'b0);
    run_req("top_unsigned", a, b, 1'b0, 0, 1'b0);

    // Signed mode: lower words stay unsigned
    run_req("signed_lower", mk(32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0),
                            mk(32'h8000_0000, 32'h0000_0001, 32'h0, 32'h0), 1'b1, 0, 1'b0);

    // Signed equal operands
    a = mk(32'h8000_0000, 32'h7FFF_FFFF, 32'hAAAA_AAAA, 32'h5555_5555);
    run_req("signed_eq", a, a, 1'b1, 0, 1'b0);

    // Backpressure with a competing request held high
    run_req("hold", mk(32'h7, 32'h9, 32'h0, 32'h0),
                    mk(32'h7, 32'h8, 32'h0, 32'h0), 1'b0, 5, 1'b1);

    // A few random compares, sharing upper words to reach deeper indices
    for (int i = 0; i < 6; i++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      if (i >= 2) b[127:96] = a[127:96];
      if (i >= 4) b[95:64]  = a[95:64];
      run_req("rand", a, b, 1'(i & 1), i % 3, 1'b0);
    end

    // Reset in the middle of an equal 4-word compare
    a = mk(32'hCAFE_F00D, 32'h1, 32'h2, 32'h3);
    @(negedge i_clk);
    check("mid_rst_ready_before", o_req_ready, 1'b1);
    i_operand_a = a;
    i_operand_b = a;
    i_req_signed = 1'b0;
    i_req_valid = 1'b1;
    sb.push_back(model(a, a, 1'b0));
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    repeat (2) begin
      @(posedge i_clk);
      @(negedge i_clk);
    end
    check_outs("mid_cmp", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    i_rst = 1'b1;
    #1;
    check_outs("mid_rst_during", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    sb.delete();
    #1;
    check_outs("mid_rst_c1", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge i_clk);
    check_outs("mid_rst_c2", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      check("mid_rst_no_rsp", o_rsp_valid, 1'b0);
    end

    // Block still works after the aborted compare
    run_req("post_rst", mk(32'h0, 32'h0, 32'h4, 32'h0),
                        mk(32'h0, 32'h0, 32'h3, 32'hFFFF_FFFF), 1'b0, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
